// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU encodings, flag positions and per-op flag masks
// for the single-entry ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_DAA = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_CLD = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_STD = 3'd7;

    localparam logic [1:0] DS_8  = 2'd0;
    localparam logic [1:0] DS_16 = 2'd1;
    localparam logic [1:0] DS_32 = 2'd2;

    localparam int CF_BIT = 0;
    localparam int PF_BIT = 2;
    localparam int AF_BIT = 4;
    localparam int ZF_BIT = 6;
    localparam int SF_BIT = 7;
    localparam int DF_BIT = 10;
    localparam int OF_BIT = 11;

    localparam logic [31:0] MASK_ARITH = 32'h0000_08D5;
    localparam logic [31:0] MASK_DF    = 32'h0000_0400;
    localparam logic [31:0] MASK_NONE  = 32'h0000_0000;

    function automatic logic [31:0] flag_mask(input logic [2:0] op);
        logic [31:0] m;
        case (op)
            OP_NOT:         m = MASK_NONE;
            OP_CLD, OP_STD: m = MASK_DF;
            default:        m = MASK_ARITH;
        endcase
        return m;
    endfunction

    function automatic logic op_wb(input logic [2:0] op);
        return !(op == OP_CMP || op == OP_CLD || op == OP_STD);
    endfunction

    function automatic logic [31:0] flag_merge(
        input logic [31:0] base,
        input logic [31:0] upd,
        input logic [31:0] mask
    );
        return (base & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu32.sv
// Combinational 32-bit ALU with x86-style flags; operands are
// truncated to the selected data size before the operation.
module alu32
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic [1:0]  datasize,
    input  logic        CF_dataforwarded,
    input  logic        AF_dataforwarded,
    output logic [31:0] result,
    output logic [31:0] flags
);

    logic [31:0] wmask;
    logic [4:0]  msb;
    logic [4:0]  sidx;
    logic [5:0]  cidx;
    logic [31:0] am;
    logic [31:0] bm;
    logic [32:0] sum;
    logic [32:0] dif;
    logic [7:0]  al;
    logic [8:0]  daa_t;
    logic        lo_adj;
    logic        hi_adj;
    logic        cf;
    logic        af;
    logic        of;
    logic        df;

    always_comb begin
        case (datasize)
            DS_8:    begin wmask = 32'h0000_00FF; msb = 5'd7;  end
            DS_16:   begin wmask = 32'h0000_FFFF; msb = 5'd15; end
            default: begin wmask = 32'hFFFF_FFFF; msb = 5'd31; end
        endcase
    end

    assign cidx = {1'b0, msb} + 6'd1;
    assign am   = a & wmask;
    assign bm   = b & wmask;
    assign sum  = {1'b0, am} + {1'b0, bm};
    assign dif  = {1'b0, am} - {1'b0, bm};

    // DAA works on the low byte only and consumes the bypassed CF/AF
    assign al     = a[7:0];
    assign lo_adj = (al[3:0] > 4'd9) || AF_dataforwarded;
    assign hi_adj = (al > 8'h99) || CF_dataforwarded;
    assign daa_t  = {1'b0, al} + (lo_adj ? 9'd6 : 9'd0)
                  + (hi_adj ? 9'h060 : 9'd0);

    always_comb begin
        result = 32'h0;
        cf     = 1'b0;
        af     = 1'b0;
        of     = 1'b0;
        df     = 1'b0;
        sidx   = msb;
        unique case (op)
            OP_ADD: begin
                result = sum[31:0] & wmask;
                cf     = sum[cidx];
                af     = am[4] ^ bm[4] ^ sum[4];
                of     = (am[msb] == bm[msb]) && (result[msb] != am[msb]);
            end
            OP_CMP: begin
                result = dif[31:0] & wmask;
                cf     = dif[cidx];
                af     = am[4] ^ bm[4] ^ dif[4];
                of     = (am[msb] != bm[msb]) && (result[msb] != am[msb]);
            end
            OP_OR:  result = am | bm;
            OP_AND: result = am & bm;
            OP_NOT: result = ~a & wmask;
            OP_DAA: begin
                result = {24'h0, daa_t[7:0]};
                cf     = hi_adj;
                af     = lo_adj;
                sidx   = 5'd7;
            end
            OP_CLD: df = 1'b0;
            OP_STD: df = 1'b1;
        endcase
    end

    always_comb begin
        flags         = 32'h0;
        flags[CF_BIT] = cf;
        flags[PF_BIT] = ~^result[7:0];
        flags[AF_BIT] = af;
        flags[ZF_BIT] = (result == 32'h0);
        flags[SF_BIT] = result[sidx];
        flags[DF_BIT] = df;
        flags[OF_BIT] = of;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-entry ALU issue stage: captures ALU results into an output
// register and commits architectural flags on the output handshake.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       in_datasize,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_wb,
    output logic [31:0]      flags_q
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]  state;
    logic [2:0]  ent_op;
    logic [31:0] ent_flags;
    logic [31:0] ent_mask;
    logic [31:0] eff_flags;
    logic [31:0] alu_res;
    logic [31:0] alu_flags;
    logic        accept;
    logic        commit;

    // pending entry's flags are bypassed so back-to-back ops see them
    assign ent_mask  = flag_mask(ent_op);
    assign eff_flags = (state == FULL)
                     ? flag_merge(flags_q, ent_flags, ent_mask)
                     : flags_q;

    assign in_ready  = clr && !flush && (state == EMPTY || out_ready);
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign commit    = out_valid && out_ready && !flush;

    alu32 u_alu (
        .a                (in_a),
        .b                (in_b),
        .op               (in_op),
        .datasize         (in_datasize),
        .CF_dataforwarded (eff_flags[CF_BIT]),
        .AF_dataforwarded (eff_flags[AF_BIT]),
        .result           (alu_res),
        .flags            (alu_flags)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= EMPTY;
            out_result <= '0;
            out_tag    <= '0;
            out_wb     <= 1'b0;
            ent_op     <= '0;
            ent_flags  <= '0;
            flags_q    <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            if (commit) begin
                flags_q <= eff_flags;
            end
            if (accept) begin
                state      <= FULL;
                out_result <= alu_res;
                out_tag    <= in_tag;
                out_wb     <= op_wb(in_op);
                ent_op     <= in_op;
                ent_flags  <= alu_flags;
            end else if (commit) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized and directed bench for alu_issue_ctrl against an
// arithmetic reference model of the ALU and the one-entry buffer.
module tb_alu_issue_ctrl;

    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [31:0]      in_a = 32'h0;
    logic [31:0]      in_b = 32'h0;
    logic [1:0]       in_datasize = 2'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_wb;
    logic [31:0]      flags_q;

    int total = 0;
    int bad = 0;

    bit               m_full;
    logic [31:0]      m_res;
    logic [31:0]      m_fl;
    logic [31:0]      m_mask;
    logic [31:0]      m_fq;
    logic [TAG_W-1:0] m_tag;
    bit               m_wb;

    alu_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_datasize (in_datasize),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_wb      (out_wb),
        .flags_q     (flags_q)
    );

    always #5 clk = ~clk;

    function automatic longint sgn(input longint v, input int w);
        longint h;
        h = longint'(1) << (w - 1);
        return (v >= h) ? v - (h << 1) : v;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [2:0] op);
        if (op == 3'd2) return 32'h0;
        if (op == 3'd5 || op == 3'd7) return 32'h400;
        return 32'h8D5;
    endfunction

    task automatic ref_alu(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [1:0]  ds,
        input  bit          cfi,
        input  bit          afi,
        output logic [31:0] r,
        output logic [31:0] fl
    );
        int w;
        int sw;
        longint m;
        longint av;
        longint bv;
        longint v;
        longint s;
        longint h;
        longint rr;
        longint al;
        longint old;
        bit cf;
        bit af;
        bit of;
        bit df;
        w  = (ds == 2'd0) ? 8 : (ds == 2'd1) ? 16 : 32;
        sw = w;
        m  = (longint'(1) << w) - 1;
        h  = longint'(1) << (w - 1);
        av = longint'(a) & m;
        bv = longint'(b) & m;
        cf = 0; af = 0; of = 0; df = 0; rr = 0;
        case (op)
            3'd0: begin
                v  = av + bv;
                rr = v & m;
                cf = v > m;
                af = ((av % 16) + (bv % 16)) > 15;
                s  = sgn(av, w) + sgn(bv, w);
                of = (s < -h) || (s > h - 1);
            end
            3'd6: begin
                rr = (av - bv) & m;
                cf = av < bv;
                af = (av % 16) < (bv % 16);
                s  = sgn(av, w) - sgn(bv, w);
                of = (s < -h) || (s > h - 1);
            end
            3'd1: rr = av | bv;
            3'd4: rr = av & bv;
            3'd2: rr = (~longint'(a)) & m;
            3'd3: begin
                al  = longint'(a) & 255;
                old = al;
                if ((al % 16) > 9 || afi) begin
                    al = al + 6;
                    af = 1;
                end
                if (old > 'h99 || cfi) begin
                    al = al + 'h60;
                    cf = 1;
                end
                rr = al & 255;
                sw = 8;
            end
            3'd5: df = 0;
            default: df = 1;
        endcase
        r      = rr[31:0];
        fl     = 32'h0;
        fl[0]  = cf;
        fl[2]  = ($countones(r[7:0]) % 2) == 0;
        fl[4]  = af;
        fl[6]  = (rr == 0);
        fl[7]  = ((rr >> (sw - 1)) & 1) == 1;
        fl[10] = df;
        fl[11] = of;
    endtask

    task automatic model_reset();
        m_full = 0;
        m_res  = 0;
        m_fl   = 0;
        m_mask = 0;
        m_fq   = 0;
        m_tag  = '0;
        m_wb   = 0;
    endtask

    task automatic drive(
        input bit          v,
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  ds,
        input int          tag
    );
        in_valid    = v;
        in_op       = op;
        in_a        = a;
        in_b        = b;
        in_datasize = ds;
        in_tag      = tag[TAG_W-1:0];
    endtask

    // one clock: check in_ready mid-cycle, advance model, check outputs
    task automatic step(input string nm);
        bit rdy;
        bit acc;
        bit hs;
        logic [31:0] eff;
        logic [31:0] r;
        logic [31:0] fl;
        #2;
        rdy = !flush && (!m_full || out_ready);
        acc = in_valid && rdy;
        hs  = m_full && out_ready && !flush;
        eff = m_full ? ((m_fq & ~m_mask) | (m_fl & m_mask)) : m_fq;
        total++;
        if (in_ready !== rdy) begin
            bad++;
            $display("FAIL %s in_ready got=%0b exp=%0b", nm, in_ready, rdy);
        end
        if (flush) begin
            m_full = 0;
        end else begin
            if (hs) m_fq = eff;
            if (acc) begin
                ref_alu(in_op, in_a, in_b, in_datasize, eff[0], eff[4], r, fl);
                m_full = 1;
                m_res  = r;
                m_fl   = fl;
                m_mask = ref_mask(in_op);
                m_tag  = in_tag;
                m_wb   = !(in_op == 3'd6 || in_op == 3'd5 || in_op == 3'd7);
            end else if (hs) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== m_full) begin
            bad++;
            $display("FAIL %s out_valid got=%0b exp=%0b", nm, out_valid, m_full);
        end
        total++;
        if (flags_q !== m_fq) begin
            bad++;
            $display("FAIL %s flags_q got=%h exp=%h", nm, flags_q, m_fq);
        end
        if (m_full) begin
            total++;
            if (out_result !== m_res || out_tag !== m_tag || out_wb !== m_wb) begin
                bad++;
                $display("FAIL %s entry got=%h/%0d/%0b exp=%h/%0d/%0b", nm,
                         out_result, out_tag, out_wb, m_res, m_tag, m_wb);
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1, 3'd0, 32'h1, 32'h2, 2'd2, 1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0
            || out_tag !== '0 || out_wb !== 1'b0 || flags_q !== 32'h0) begin
            bad++;
            $display("FAIL reset rdy=%0b ov=%0b res=%h tag=%0d wb=%0b fq=%h",
                     in_ready, out_valid, out_result, out_tag, out_wb, flags_q);
        end
        model_reset();
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        clr = 1'b1;
    endtask

    task automatic test_add_wrap();
        out_ready = 1'b1;
        drive(1, 3'd0, 32'hFFFF_FFFF, 32'h1, 2'd2, 5);
        step("add_wrap");
        total++;
        if (out_result !== 32'h0 || out_wb !== 1'b1) begin
            bad++;
            $display("FAIL add_wrap res=%h wb=%0b exp=0/1", out_result, out_wb);
        end
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        step("add_wrap_drain");
        total++;
        if (flags_q !== 32'h55) begin
            bad++;
            $display("FAIL add_wrap_flags got=%h exp=00000055", flags_q);
        end
    endtask

    task automatic test_daa();
        test_reset();
        out_ready = 1'b1;
        drive(1, 3'd3, 32'h9A, 32'h0, 2'd0, 2);
        step("daa");
        total++;
        if (out_result !== 32'h0) begin
            bad++;
            $display("FAIL daa res=%h exp=0", out_result);
        end
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        step("daa_drain");
        total++;
        if (flags_q !== 32'h55) begin
            bad++;
            $display("FAIL daa_flags got=%h exp=00000055", flags_q);
        end
    endtask

    task automatic test_bypass();
        test_reset();
        out_ready = 1'b1;
        drive(1, 3'd0, 32'h9, 32'h9, 2'd0, 1);
        step("bypass_add");
        drive(1, 3'd3, 32'h12, 32'h0, 2'd0, 2);
        step("bypass_daa");
        total++;
        if (out_result !== 32'h18) begin
            bad++;
            $display("FAIL bypass res=%h exp=18", out_result);
        end
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        step("bypass_drain");
    endtask

    task automatic test_cmp_std();
        out_ready = 1'b1;
        drive(1, 3'd6, 32'h5, 32'h5, 2'd2, 3);
        step("cmp");
        total++;
        if (out_wb !== 1'b0) begin
            bad++;
            $display("FAIL cmp_wb got=%0b exp=0", out_wb);
        end
        drive(1, 3'd7, 32'h0, 32'h0, 2'd2, 4);
        step("std");
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        step("std_drain");
        total++;
        if (flags_q[10] !== 1'b1 || flags_q[6] !== 1'b1) begin
            bad++;
            $display("FAIL cmp_std df=%0b zf=%0b exp=1/1", flags_q[10], flags_q[6]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] saved;
        out_ready = 1'b1;
        drive(1, 3'd1, $urandom, $urandom, 2'd2, 0);
        step("stall_load");
        saved = out_result;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd0, $urandom, $urandom, 2'd1, 7);
            step("stall_hold");
            total++;
            if (out_result !== saved || out_tag !== 3'd0) begin
                bad++;
                $display("FAIL stall_stable res=%h tag=%0d exp=%h/0", out_result, out_tag, saved);
            end
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3'd4, $urandom, $urandom, 2'd2, i);
            step("stall_release");
            total++;
            if (out_valid !== 1'b1 || out_tag !== i[TAG_W-1:0]) begin
                bad++;
                $display("FAIL release ov=%0b tag=%0d exp=1/%0d", out_valid, out_tag, i);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] saved;
        out_ready = 1'b1;
        drive(1, 3'd0, 32'h7FFF_FFFF, 32'h1, 2'd2, 6);
        step("flush_load");
        saved = flags_q;
        flush = 1'b1;
        drive(1, 3'd0, 32'h1, 32'h1, 2'd2, 5);
        step("flush");
        total++;
        if (out_valid !== 1'b0 || flags_q !== saved) begin
            bad++;
            $display("FAIL flush ov=%0b fq=%h exp=0/%h", out_valid, flags_q, saved);
        end
        flush = 1'b0;
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        step("flush_after");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom % 2 == 0) ? $urandom : ($urandom % 256);
            b = ($urandom % 2 == 0) ? $urandom : ($urandom % 256);
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            drive(($urandom % 4) != 0, 3'($urandom % 8), a, b,
                  2'($urandom % 4), int'($urandom % 8));
            step("random");
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1, 3'd0, 32'h80, 32'h80, 2'd0, 3);
        step("mid_load");
        #2;
        clr = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0
            || out_tag !== '0 || out_wb !== 1'b0 || flags_q !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid rdy=%0b ov=%0b res=%h tag=%0d wb=%0b fq=%h",
                     in_ready, out_valid, out_result, out_tag, out_wb, flags_q);
        end
        model_reset();
        @(posedge clk);
        #1;
        drive(0, 3'd0, 0, 0, 2'd0, 0);
        clr = 1'b1;
        step("post_reset");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_wrap();
        test_daa();
        test_bypass();
        test_cmp_std();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
